// File: rtl/fused_layer_sequencer_if.sv
// rtl/fused_layer_sequencer_if.sv - host/fused-top bundle seen by the layer sequencer
// master = host and fused top side, slave = sequencer.
interface fused_layer_sequencer_if #(
  parameter int LAYER_W = 3
);
  logic               cfg_we;
  logic [LAYER_W-1:0] cfg_layer;
  logic [2:0]         cfg_field;
  logic [31:0]        cfg_wdata;
  logic [LAYER_W:0]   num_layers;
  logic               seq_start;
  logic               seq_abort;
  logic               done_compute;

  logic [31:0]        base_addr_IFM;
  logic [31:0]        size_IFM;
  logic [31:0]        base_addr_Weight_layer_1;
  logic [31:0]        size_Weight_layer_1;
  logic [31:0]        base_addr_Weight_layer_2;
  logic [31:0]        size_Weight_layer_2;
  logic [3:0]         KERNEL_W;
  logic [7:0]         OFM_W;
  logic [7:0]         OFM_C;
  logic [7:0]         IFM_C;
  logic [7:0]         IFM_W;
  logic [7:0]         IFM_C_layer2;
  logic [7:0]         OFM_C_layer2;
  logic [1:0]         stride;
  logic               start;
  logic               busy;
  logic [LAYER_W-1:0] cur_layer;
  logic               seq_done;
  logic               seq_err;

  modport master (
    output cfg_we, cfg_layer, cfg_field, cfg_wdata, num_layers,
           seq_start, seq_abort, done_compute,
    input  base_addr_IFM, size_IFM, base_addr_Weight_layer_1, size_Weight_layer_1,
           base_addr_Weight_layer_2, size_Weight_layer_2, KERNEL_W, OFM_W, OFM_C,
           IFM_C, IFM_W, IFM_C_layer2, OFM_C_layer2, stride,
           start, busy, cur_layer, seq_done, seq_err
  );

  modport slave (
    input  cfg_we, cfg_layer, cfg_field, cfg_wdata, num_layers,
           seq_start, seq_abort, done_compute,
    output base_addr_IFM, size_IFM, base_addr_Weight_layer_1, size_Weight_layer_1,
           base_addr_Weight_layer_2, size_Weight_layer_2, KERNEL_W, OFM_W, OFM_C,
           IFM_C, IFM_W, IFM_C_layer2, OFM_C_layer2, stride,
           start, busy, cur_layer, seq_done, seq_err
  );
endinterface

// File: rtl/fused_layer_sequencer.sv
// rtl/fused_layer_sequencer.sv - walks a host-written descriptor table, one fused-top layer at a time
// Outputs are registered from the next-state decision so each is valid for the whole state it names.
module fused_layer_sequencer #(
  parameter int          MAX_LAYERS  = 8,
  parameter int          LAYER_W     = 3,
  parameter logic [23:0] WDOG_CYCLES = 24'hFFFFFF
) (
  input logic                   clk,
  input logic                   reset_n,
  fused_layer_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_NEXT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [LAYER_W:0] MAX_CNT = (LAYER_W + 1)'(MAX_LAYERS);
  localparam logic [LAYER_W:0] ONE_CNT = (LAYER_W + 1)'(1);

  logic [7:0][31:0]   desc_q [MAX_LAYERS];
  logic               tbl_we;

  state_t             state_q, state_d;
  logic [LAYER_W-1:0] layer_idx_q, layer_idx_d;
  logic [LAYER_W:0]   count_q, count_d;
  logic [23:0]        wdog_q, wdog_d;
  logic [6:0][31:0]   cfg_word_q, cfg_word_d;
  logic [21:0]        cfg_tail_q, cfg_tail_d;
  logic               done_prev_q, done_prev_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic               seq_done_q, seq_done_d;
  logic               seq_err_q, seq_err_d;
  logic               done_rise;

  // Only a fresh rising edge counts; a level held over from the previous layer must not advance.
  assign done_rise = bus.done_compute & ~done_prev_q;

  always_comb begin
    state_d     = state_q;
    layer_idx_d = layer_idx_q;
    count_d     = count_q;
    wdog_d      = wdog_q;
    cfg_word_d  = cfg_word_q;
    cfg_tail_d  = cfg_tail_q;
    done_prev_d = bus.done_compute;
    start_d     = 1'b0;
    busy_d      = busy_q;
    seq_done_d  = 1'b0;
    seq_err_d   = seq_err_q;
    tbl_we      = 1'b0;

    if (bus.cfg_we) begin
      if (state_q == S_IDLE) tbl_we = 1'b1;
      else                   seq_err_d = 1'b1;
    end

    if (bus.seq_abort) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.seq_start) begin
            count_d     = (bus.num_layers > MAX_CNT) ? MAX_CNT : bus.num_layers;
            layer_idx_d = '0;
            seq_err_d   = 1'b0;
            if (bus.num_layers == '0) begin
              state_d    = S_DONE;
              seq_done_d = 1'b1;
              busy_d     = 1'b0;
            end else begin
              state_d = S_LOAD;
              busy_d  = 1'b1;
            end
          end
        end
        S_LOAD: begin
          cfg_word_d = desc_q[layer_idx_q][6:0];
          cfg_tail_d = desc_q[layer_idx_q][7][21:0];
          start_d    = 1'b1;
          state_d    = S_START;
        end
        S_START: begin
          wdog_d  = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (done_rise) begin
            state_d = S_NEXT;
          end else if (wdog_q == WDOG_CYCLES - 24'd1) begin
            state_d   = S_ERR;
            seq_err_d = 1'b1;
            busy_d    = 1'b0;
          end else begin
            wdog_d = wdog_q + 24'd1;
          end
        end
        S_NEXT: begin
          if (({1'b0, layer_idx_q} + ONE_CNT) == count_q) begin
            state_d    = S_DONE;
            seq_done_d = 1'b1;
            busy_d     = 1'b0;
          end else begin
            layer_idx_d = layer_idx_q + LAYER_W'(1);
            state_d     = S_LOAD;
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_ERR:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      layer_idx_q <= '0;
      count_q     <= '0;
      wdog_q      <= '0;
      cfg_word_q  <= '0;
      cfg_tail_q  <= '0;
      done_prev_q <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      seq_done_q  <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      layer_idx_q <= layer_idx_d;
      count_q     <= count_d;
      wdog_q      <= wdog_d;
      cfg_word_q  <= cfg_word_d;
      cfg_tail_q  <= cfg_tail_d;
      done_prev_q <= done_prev_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      seq_done_q  <= seq_done_d;
      seq_err_q   <= seq_err_d;
    end
  end

  // Table contents survive reset; the host rewrites descriptors before relying on them.
  always_ff @(posedge clk) begin
    if (tbl_we) desc_q[bus.cfg_layer][bus.cfg_field] <= bus.cfg_wdata;
  end

  assign bus.base_addr_IFM            = cfg_word_q[0];
  assign bus.size_IFM                 = cfg_word_q[1];
  assign bus.base_addr_Weight_layer_1 = cfg_word_q[2];
  assign bus.size_Weight_layer_1      = cfg_word_q[3];
  assign bus.base_addr_Weight_layer_2 = cfg_word_q[4];
  assign bus.size_Weight_layer_2      = cfg_word_q[5];
  assign bus.IFM_W                    = cfg_word_q[6][31:24];
  assign bus.IFM_C                    = cfg_word_q[6][23:16];
  assign bus.OFM_C                    = cfg_word_q[6][15:8];
  assign bus.OFM_W                    = cfg_word_q[6][7:0];
  assign bus.KERNEL_W                 = cfg_tail_q[21:18];
  assign bus.stride                   = cfg_tail_q[17:16];
  assign bus.IFM_C_layer2             = cfg_tail_q[15:8];
  assign bus.OFM_C_layer2             = cfg_tail_q[7:0];
  assign bus.start                    = start_q;
  assign bus.busy                     = busy_q;
  assign bus.cur_layer                = layer_idx_q;
  assign bus.seq_done                 = seq_done_q;
  assign bus.seq_err                  = seq_err_q;

endmodule
